// File: rtl/fifo_gray_pkg.sv
// rtl/fifo_gray_pkg.sv - Gray/binary conversion and popcount helpers for the FIFO pointer controller
package fifo_gray_pkg;

  // Binary to reflected Gray code
  function automatic logic [31:0] bin2gray_f(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code back to binary (prefix XOR from the MSB down)
  function automatic logic [31:0] gray2bin_f(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Number of set bits, used to measure how many Gray bits moved in one cycle
  function automatic int unsigned popcount_f(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fifo_gray_ptr_ctrl_gray_ptr.sv
// rtl/fifo_gray_ptr_ctrl_gray_ptr.sv - registered binary + Gray pointer with increment, exposing current and next values
module gray_ptr
  import fifo_gray_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             inc,
  output logic [WIDTH-1:0] bin_cur,
  output logic [WIDTH-1:0] gray_cur,
  output logic [WIDTH-1:0] bin_nxt,
  output logic [WIDTH-1:0] gray_nxt
);

  logic [31:0] gray_wide;

  // Next pointer: binary wraps naturally at 2^WIDTH, Gray derived from it
  always_comb begin
    bin_nxt   = bin_cur + WIDTH'(inc);
    gray_wide = bin2gray_f(32'(bin_nxt));
    gray_nxt  = gray_wide[WIDTH-1:0];
  end

  // Binary and Gray registered together so they never disagree
  always_ff @(posedge clk) begin
    if (!nrst) begin
      bin_cur  <= '0;
      gray_cur <= '0;
    end else begin
      bin_cur  <= bin_nxt;
      gray_cur <= gray_nxt;
    end
  end

endmodule

// File: rtl/fifo_gray_ptr_ctrl.sv
// rtl/fifo_gray_ptr_ctrl.sv - FIFO pointer controller: arbitration, Gray pointers, registered flags; optional FIFO_GRAY_CHECK_EN Gray-step checker
module fifo_gray_ptr_ctrl
  import fifo_gray_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int AFULL_THR  = 12,
  parameter int AEMPTY_THR = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       w_req,
  input  logic                       r_req,
  output logic                       w_ena,
  output logic                       r_ena,
  output logic [$clog2(DEPTH)-1:0]   w_addr,
  output logic [$clog2(DEPTH)-1:0]   r_addr,
  output logic [$clog2(DEPTH):0]     w_ptr_gray,
  output logic [$clog2(DEPTH):0]     r_ptr_gray,
  output logic [$clog2(DEPTH):0]     usedw,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       w_fail,
  output logic                       r_fail,
  output logic                       gray_err
);

  localparam int AW = $clog2(DEPTH);
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal
  localparam logic [AW:0] FULL_MASK = (AW+1)'(3) << (AW - 1);
  localparam logic [AW:0] AFULL_V   = (AW+1)'(AFULL_THR);
  localparam logic [AW:0] AEMPTY_V  = (AW+1)'(AEMPTY_THR);

  logic [AW:0] w_bin_cur, w_bin_nxt, w_gray_nxt;
  logic [AW:0] r_bin_cur, r_bin_nxt, r_gray_nxt;
  logic [AW:0] usedw_nxt;

  // Requests are judged only against registered flags; reset blocks RAM strobes
  always_comb begin
    w_ena = nrst & w_req & ~full;
    r_ena = nrst & r_req & ~empty;
  end

  gray_ptr #(.WIDTH(AW + 1)) u_w_ptr (
    .clk      (clk),
    .nrst     (nrst),
    .inc      (w_ena),
    .bin_cur  (w_bin_cur),
    .gray_cur (w_ptr_gray),
    .bin_nxt  (w_bin_nxt),
    .gray_nxt (w_gray_nxt)
  );

  gray_ptr #(.WIDTH(AW + 1)) u_r_ptr (
    .clk      (clk),
    .nrst     (nrst),
    .inc      (r_ena),
    .bin_cur  (r_bin_cur),
    .gray_cur (r_ptr_gray),
    .bin_nxt  (r_bin_nxt),
    .gray_nxt (r_gray_nxt)
  );

  // RAM addresses drop the lap bit; occupancy from next pointers
  always_comb begin
    w_addr    = w_bin_cur[AW-1:0];
    r_addr    = r_bin_cur[AW-1:0];
    usedw_nxt = w_bin_nxt - r_bin_nxt;
  end

  // Status flags and fail pulses registered from next-pointer values
  always_ff @(posedge clk) begin
    if (!nrst) begin
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      w_fail       <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      usedw        <= usedw_nxt;
      empty        <= (w_gray_nxt == r_gray_nxt);
      full         <= (w_gray_nxt == (r_gray_nxt ^ FULL_MASK));
      almost_empty <= (usedw_nxt <= AEMPTY_V);
      almost_full  <= (usedw_nxt >= AFULL_V);
      w_fail       <= w_req & full;
      r_fail       <= r_req & empty;
    end
  end

`ifdef FIFO_GRAY_CHECK_EN
  logic [AW:0] w_gray_q, r_gray_q;
  logic        w_adv_q, r_adv_q;
  int unsigned w_step, r_step;
  logic        step_viol;

  // Bits moved by each registered Gray pointer since the previous cycle
  always_comb begin
    w_step    = popcount_f(32'(w_ptr_gray ^ w_gray_q));
    r_step    = popcount_f(32'(r_ptr_gray ^ r_gray_q));
    step_viol = (w_step > 1) || (!w_adv_q && (w_step != 0)) ||
                (r_step > 1) || (!r_adv_q && (r_step != 0));
  end

  // Track previous pointers and flag any illegal Gray step (sticky)
  always_ff @(posedge clk) begin
    if (!nrst) begin
      w_gray_q <= '0;
      r_gray_q <= '0;
      w_adv_q  <= 1'b0;
      r_adv_q  <= 1'b0;
      gray_err <= 1'b0;
    end else begin
      w_gray_q <= w_ptr_gray;
      r_gray_q <= r_ptr_gray;
      w_adv_q  <= w_ena;
      r_adv_q  <= r_ena;
      if (step_viol) begin
        gray_err <= 1'b1;
      end
      assert (!step_viol) else $error("gray pointer step violation w=%0d r=%0d", w_step, r_step);
    end
  end
`else
  // Checker not built
  always_comb gray_err = 1'b0;
`endif

endmodule
